// File: rtl/triad_decoder.sv
// Per-distrip comparator triad deserializer producing a stretched halfstrip image,
// with saturating counts of decoded triads and of start bits dropped while holding.
module triad_decoder #(
    parameter int NDISTRIP = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NDISTRIP-1:0]   triad_in,
    input  logic                  decode_en,
    input  logic [3:0]            persist,
    input  logic                  cnt_rst,
    output logic [4*NDISTRIP-1:0] halfstrips,
    output logic                  triad_strobe,
    output logic [31:0]           triad_cnt,
    output logic [31:0]           skip_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int CW = $clog2(NDISTRIP + 1);

    // Per-distrip FSM state, kept as named arrays so checkers can bind to them.
    state_t              state_q    [NDISTRIP];
    state_t              state_d    [NDISTRIP];
    logic [3:0]          hcnt_q     [NDISTRIP];
    logic [3:0]          hcnt_d     [NDISTRIP];
    logic [3:0]          hold_len_q [NDISTRIP];
    logic [3:0]          hold_len_d [NDISTRIP];
    logic [NDISTRIP-1:0] b1_q, b1_d;
    logic [NDISTRIP-1:0] capture, skip;
    logic [4*NDISTRIP-1:0] hs_d;
    logic [CW-1:0]       cap_n, skip_n;
    logic [32:0]         tc_sum, sk_sum;

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        hold_len_d = hold_len_q;
        b1_d       = b1_q;
        hs_d       = halfstrips;
        capture    = '0;
        skip       = '0;
        for (int d = 0; d < NDISTRIP; d++) begin
            if (!decode_en) begin
                state_d[d]      = S_IDLE;
                hs_d[4*d +: 4]  = 4'b0000;
            end else begin
                case (state_q[d])
                    S_IDLE: if (triad_in[d]) state_d[d] = S_B1;
                    S_B1: begin
                        b1_d[d]    = triad_in[d];
                        state_d[d] = S_B2;
                    end
                    S_B2: begin
                        hs_d[4*d +: 4] = 4'b0001 << {b1_q[d], triad_in[d]};
                        hold_len_d[d]  = persist;
                        hcnt_d[d]      = 4'd0;
                        capture[d]     = 1'b1;
                        state_d[d]     = S_HOLD;
                    end
                    S_HOLD: begin
                        // Start bits seen while holding are dropped, exit edge included.
                        skip[d] = triad_in[d];
                        if (hcnt_q[d] == hold_len_q[d]) begin
                            hs_d[4*d +: 4] = 4'b0000;
                            state_d[d]     = S_IDLE;
                        end else begin
                            hcnt_d[d] = hcnt_q[d] + 4'd1;
                        end
                    end
                    default: state_d[d] = S_IDLE;
                endcase
            end
        end
    end

    assign cap_n  = CW'($countones(capture));
    assign skip_n = CW'($countones(skip));
    assign tc_sum = {1'b0, triad_cnt} + 33'(cap_n);
    assign sk_sum = {1'b0, skip_cnt} + 33'(skip_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDISTRIP; d++) begin
                state_q[d]    <= S_IDLE;
                hcnt_q[d]     <= 4'd0;
                hold_len_q[d] <= 4'd0;
            end
            b1_q         <= '0;
            halfstrips   <= '0;
            triad_strobe <= 1'b0;
            triad_cnt    <= 32'd0;
            skip_cnt     <= 32'd0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            hold_len_q   <= hold_len_d;
            b1_q         <= b1_d;
            halfstrips   <= hs_d;
            triad_strobe <= |capture;
            if (cnt_rst) begin
                triad_cnt <= 32'd0;
                skip_cnt  <= 32'd0;
            end else begin
                triad_cnt <= tc_sum[32] ? 32'hFFFF_FFFF : tc_sum[31:0];
                skip_cnt  <= sk_sum[32] ? 32'hFFFF_FFFF : sk_sum[31:0];
            end
        end
    end

endmodule

// File: tb/tb_triad_decoder.sv
// Bench for triad_decoder: directed triads with literal expectations plus a random
// run, all compared each cycle against an edge-timeline model of the decoder.
module tb_triad_decoder;
    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] triad_in = '0;
    logic          decode_en = 1'b0;
    logic [3:0]    persist = 4'd0;
    logic          cnt_rst = 1'b0;
    logic [4*ND-1:0] halfstrips;
    logic          triad_strobe;
    logic [31:0]   triad_cnt;
    logic [31:0]   skip_cnt;

    triad_decoder #(.NDISTRIP(ND)) dut (
        .clk(clk), .rst_n(rst_n), .triad_in(triad_in), .decode_en(decode_en),
        .persist(persist), .cnt_rst(cnt_rst), .halfstrips(halfstrips),
        .triad_strobe(triad_strobe), .triad_cnt(triad_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each distrip remembers the edge index of its accepted start bit;
    // everything else follows from the offset of the current edge from it.
    int          st     [ND];
    int          plen   [ND];
    logic        mb1    [ND];
    longint      edge_n;
    logic [31:0] exp_hs;
    logic        exp_strobe;
    longint      exp_tc, exp_sk;

    always @(posedge clk or negedge rst_n) begin : model
        int caps, skips;
        longint off;
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                st[d] = -1; plen[d] = 0; mb1[d] = 1'b0;
            end
            exp_hs = '0; exp_strobe = 1'b0; exp_tc = 0; exp_sk = 0; edge_n = 0;
        end else begin
            caps = 0; skips = 0;
            if (decode_en) begin
                for (int d = 0; d < ND; d++) begin
                    if (st[d] >= 0) begin
                        off = edge_n - st[d];
                        if (off == 1) mb1[d] = triad_in[d];
                        else if (off == 2) begin
                            exp_hs[4*d +: 4] = 4'b0000;
                            exp_hs[4*d + 2*mb1[d] + triad_in[d]] = 1'b1;
                            plen[d] = persist;
                            caps++;
                        end else begin
                            if (triad_in[d]) skips++;
                            if (off == 3 + plen[d]) begin
                                exp_hs[4*d +: 4] = 4'b0000;
                                st[d] = -1;
                            end
                        end
                    end else if (triad_in[d]) begin
                        st[d] = int'(edge_n);
                    end
                end
            end else begin
                for (int d = 0; d < ND; d++) st[d] = -1;
                exp_hs = '0;
            end
            exp_strobe = (caps > 0);
            if (cnt_rst) begin
                exp_tc = 0; exp_sk = 0;
            end else begin
                exp_tc = exp_tc + caps;
                exp_sk = exp_sk + skips;
                if (exp_tc > 64'hFFFF_FFFF) exp_tc = 64'hFFFF_FFFF;
                if (exp_sk > 64'hFFFF_FFFF) exp_sk = 64'hFFFF_FFFF;
            end
            edge_n++;
        end
    end

    always @(negedge clk) begin : compare
        if (rst_n) begin
            chk("halfstrips", halfstrips, exp_hs);
            chk("triad_strobe", {31'd0, triad_strobe}, {31'd0, exp_strobe});
            chk("triad_cnt", triad_cnt, exp_tc[31:0]);
            chk("skip_cnt", skip_cnt, exp_sk[31:0]);
        end
    end

    // Drive one sample, let the edge take it, return at the following negedge.
    task automatic step(input logic [ND-1:0] v);
        triad_in = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        triad_in = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int hi;
        decode_en = 1'b1;
        do_reset();
        chk("reset_hs", halfstrips, 32'h0);
        chk("reset_tc", triad_cnt, 32'h0);

        // Single triad on distrip 2, persist 0.
        persist = 4'd0;
        step(8'h00);
        step(8'h04); step(8'h04); step(8'h00);
        chk("t1_hs", halfstrips, 32'h0000_0400);
        chk("t1_strobe", {31'd0, triad_strobe}, 32'd1);
        chk("t1_tc", triad_cnt, 32'd1);
        step(8'h00);
        chk("t1_hs_clear", halfstrips, 32'h0);
        chk("t1_strobe_once", {31'd0, triad_strobe}, 32'd0);

        // Distrip 7 held high through a persist=3 hold and into a second triad.
        do_reset();
        persist = 4'd3;
        step(8'h80); step(8'h80); step(8'h80);
        chk("t2_hs", halfstrips, 32'h8000_0000);
        hi = 1;
        for (int i = 0; i < 8; i++) begin
            step(8'h80);
            if (halfstrips[31] && i < 4) hi++;
            if (i == 3) chk("t2_skip", skip_cnt, 32'd4);
        end
        chk("t2_hold_cycles", hi, 32'd4);
        chk("t2_second_tc", triad_cnt, 32'd2);
        for (int i = 0; i < 6; i++) step(8'h00);

        // All distrips capture 1,0,1 together.
        do_reset();
        persist = 4'd0;
        step(8'hFF); step(8'h00); step(8'hFF);
        chk("t3_hs", halfstrips, 32'h2222_2222);
        chk("t3_tc", triad_cnt, 32'd8);
        chk("t3_strobe", {31'd0, triad_strobe}, 32'd1);
        step(8'h00);
        chk("t3_strobe_once", {31'd0, triad_strobe}, 32'd0);

        // Saturation from a preloaded count, then clear on a capture edge.
        do_reset();
        #2;
        force dut.triad_cnt = 32'hFFFF_FFFE;
        exp_tc = 64'hFFFF_FFFE;
        #1;
        release dut.triad_cnt;
        step(8'h07); step(8'h07); step(8'h00);
        chk("t4_hs", halfstrips, 32'h0000_0444);
        chk("t4_sat", triad_cnt, 32'hFFFF_FFFF);
        step(8'h00);
        step(8'h01); step(8'h00);
        cnt_rst = 1'b1;
        step(8'h01);
        cnt_rst = 1'b0;
        chk("t4_cnt_rst", triad_cnt, 32'd0);
        chk("t4_hs2", halfstrips, 32'h0000_0002);
        step(8'h00);

        // Asynchronous reset mid-hold, then a triad right at reset release.
        do_reset();
        persist = 4'd15;
        step(8'h01); step(8'h01); step(8'h01);
        chk("t5_hs", halfstrips, 32'h0000_0008);
        step(8'h00); step(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_hs", halfstrips, 32'h0);
        chk("t5_async_tc", triad_cnt, 32'h0);
        chk("t5_async_sk", skip_cnt, 32'h0);
        triad_in = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        persist = 4'd0;
        step(8'h01); step(8'h01); step(8'h00);
        chk("t5_release_hs", halfstrips, 32'h0000_0004);
        chk("t5_release_tc", triad_cnt, 32'd1);
        step(8'h00);

        // Disable after the start bit aborts the triad.
        do_reset();
        step(8'h01);
        decode_en = 1'b0;
        step(8'h01); step(8'h00);
        decode_en = 1'b1;
        step(8'h00); step(8'h00);
        chk("t6_hs", halfstrips, 32'h0);
        chk("t6_tc", triad_cnt, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            persist   = 4'($urandom_range(0, 15));
            decode_en = ($urandom_range(0, 63) != 0);
            cnt_rst   = ($urandom_range(0, 199) == 0);
            step(ND'($urandom & $urandom));
        end
        cnt_rst = 1'b0;
        decode_en = 1'b1;
        for (int i = 0; i < 20; i++) step(8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
